instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 96 +++++++++
 tb/tb_instr_fetch.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: a two-state FETCH/HOLD machine that requests a word,
// holds it until downstream retires it, then advances pc sequentially or to a branch target.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        pc_src,
    input  logic [31:0] imm,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misalign,
    output logic [31:0] instret
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instret_q, instret_d;
    logic        misalign_q, misalign_d;
    logic [31:0] branch_target;

    assign pc_plus4      = pc_q + 32'd4;
    assign branch_target = pc_q + imm;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        instret_d   = instret_q;
        misalign_d  = 1'b0;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    state_d   = FETCH;
                    instret_d = instret_q + 32'd1;
                    // Misaligned branch targets are forced to a word boundary and flagged.
                    if (pc_src) begin
                        pc_d       = {branch_target[31:2], 2'b00};
                        misalign_d = |branch_target[1:0];
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= NOP;
            instret_q  <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instret_q  <= instret_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign instr     = instr_q;
    assign instret   = instret_q;
    assign misalign  = misalign_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a transaction-level model checked against the DUT every cycle,
// plus literal expectations for sequential fetch, wait, stall, branch, wrap and reset cases.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        pc_src;
    logic [31:0] imm;

    logic        imem_req, instr_valid, misalign;
    logic [31:0] imem_addr, instr, pc, pc_plus4, instret;

    logic        imem_req2, instr_valid2, misalign2;
    logic [31:0] imem_addr2, instr2, pc2, pc_plus42, instret2;

    int checks;
    int failures;

    // Model state: whether a word is held, plus the architecturally visible values.
    logic        mdlHold;
    logic [31:0] mdlPc, mdlInstr, mdlInstret;
    logic        mdlMis;
    logic        mdlValid;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid),
        .stall(stall), .pc_src(pc_src), .imm(imm),
        .pc(pc), .pc_plus4(pc_plus4), .misalign(misalign), .instret(instret)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst(rst),
        .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr(instr2), .instr_valid(instr_valid2),
        .stall(stall), .pc_src(pc_src), .imm(imm),
        .pc(pc2), .pc_plus4(pc_plus42), .misalign(misalign2), .instret(instret2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    // Advance the model by one clock edge from the inputs seen at that edge.
    task automatic modelStep();
        logic [31:0] target;
        if (rst) begin
            mdlHold    = 1'b0;
            mdlPc      = 32'h0000_0000;
            mdlInstr   = 32'h0000_0013;
            mdlInstret = 32'd0;
            mdlMis     = 1'b0;
            mdlValid   = 1'b1;
        end else begin
            mdlMis = 1'b0;
            if (!mdlHold) begin
                if (imem_ready) begin
                    mdlInstr = imem_rdata;
                    mdlHold  = 1'b1;
                end
            end else if (!stall) begin
                if (pc_src) begin
                    target = mdlPc + imm;
                    mdlMis = (target[1:0] != 2'b00);
                    mdlPc  = target & 32'hFFFF_FFFC;
                end else begin
                    mdlPc = mdlPc + 32'd4;
                end
                mdlInstret = mdlInstret + 32'd1;
                mdlHold    = 1'b0;
            end
        end
    endtask

    task automatic compareModel();
        if (mdlValid) begin
            checkOutput("imem_req",    {31'd0, imem_req},    {31'd0, !mdlHold});
            checkOutput("imem_addr",   imem_addr,            mdlPc);
            checkOutput("instr_valid", {31'd0, instr_valid}, {31'd0, mdlHold});
            checkOutput("instr",       instr,                mdlInstr);
            checkOutput("pc",          pc,                   mdlPc);
            checkOutput("pc_plus4",    pc_plus4,             mdlPc + 32'd4);
            checkOutput("misalign",    {31'd0, misalign},    {31'd0, mdlMis});
            checkOutput("instret",     instret,              mdlInstret);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic rdy, input logic [31:0] rd,
                                 input logic st, input logic ps, input logic [31:0] im);
        rst = r; imem_ready = rdy; imem_rdata = rd; stall = st; pc_src = ps; imm = im;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        compareModel();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        mdlValid = 1'b0;
        mdlHold  = 1'b0;
        mdlPc = '0; mdlInstr = '0; mdlInstret = '0; mdlMis = 1'b0;

        // Reset with fetch data present: reset must win.
        applyStimulus(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0);
        checkOutput("rst_addr",    imem_addr, 32'h0);
        checkOutput("rst_req",     {31'd0, imem_req}, 32'd1);
        checkOutput("rst_instr",   instr, 32'h0000_0013);
        checkOutput("rst_instret", instret, 32'd0);

        // Sequential fetch at full throughput.
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1'b0, 1'b1, 32'h00A0_0093, 1'b0, 1'b0, 32'd0);
            checkOutput("seq_valid", {31'd0, instr_valid}, (i % 2 == 1) ? 32'd1 : 32'd0);
            if (i == 2) checkOutput("seq_addr4", imem_addr, 32'h4);
            if (i == 4) checkOutput("seq_addr8", imem_addr, 32'h8);
        end
        checkOutput("seq_instret3", instret, 32'd3);

        // Advance to pc=0x10, then hold ready low for three cycles.
        applyStimulus(1'b0, 1'b1, 32'h00A0_0093, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h1111_1111, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h2222_2222, 1'b1, 1'b1, 32'h40);
            checkOutput("wait_addr",  imem_addr, 32'h10);
            checkOutput("wait_req",   {31'd0, imem_req}, 32'd1);
            checkOutput("wait_valid", {31'd0, instr_valid}, 32'd0);
        end
        applyStimulus(1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'd0);
        checkOutput("wait_instr", instr, 32'h1234_5678);

        // Stall with toggling branch inputs and changing memory data.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 32'hA5A5_0000 + i, 1'b1, i[0], 32'h100 + i);
            checkOutput("stall_pc",    pc, 32'h10);
            checkOutput("stall_instr", instr, 32'h1234_5678);
            checkOutput("stall_instret", instret, 32'd4);
        end
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h8);
        checkOutput("stall_release_pc", pc, 32'h14);

        // Branches: jump to 0x100, back by 0x10, forward again, then misaligned target.
        applyStimulus(1'b0, 1'b1, 32'h0000_0063, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'hEC);
        checkOutput("br_pc100", pc, 32'h100);
        applyStimulus(1'b0, 1'b1, 32'h0000_0063, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFF0);
        checkOutput("br_back", pc, 32'hF0);
        checkOutput("br_back_mis", {31'd0, misalign}, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h0000_0063, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h10);
        applyStimulus(1'b0, 1'b1, 32'h0000_0063, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h6);
        checkOutput("br_mis_pc", pc, 32'h104);
        checkOutput("br_mis_pulse", {31'd0, misalign}, 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'd0);
        checkOutput("br_mis_clear", {31'd0, misalign}, 32'd0);

        // Reset while holding, with a simultaneous taken-branch retire.
        applyStimulus(1'b0, 1'b1, 32'h0000_00B3, 1'b1, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b1, 32'h0, 1'b0, 1'b1, 32'h40);
        checkOutput("rmid_pc",      pc, 32'h0);
        checkOutput("rmid_instr",   instr, 32'h0000_0013);
        checkOutput("rmid_valid",   {31'd0, instr_valid}, 32'd0);
        checkOutput("rmid_instret", instret, 32'd0);
        checkOutput("rmid_pc2",     pc2, 32'hFFFF_FFFC);

        // PC wrap on the second instance, instret wrap via a preset value on the first.
        applyStimulus(1'b0, 1'b1, 32'h0000_0013, 1'b1, 1'b0, 32'd0);
        checkOutput("wrap_pc_plus4", pc_plus42, 32'h0);
        force dut.instret_q = 32'hFFFF_FFFF;
        mdlInstret = 32'hFFFF_FFFF;
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'd0);
        release dut.instret_q;
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'd0);
        checkOutput("wrap_pc",       pc2, 32'h0);
        checkOutput("wrap_instret",  instret, 32'h0);
        checkOutput("wrap_instret2", instret2, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
